hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core (F, D, X, M, W).
- Keeps a 3-entry scoreboard (X, M, W) of in-flight destination registers.
- Drives stall and flush for the F/D and D/X pipeline registers.
- Drives the forwarding selects for the execute stage's rs1/rs2 operands.
- Holds saturating performance counters for stall and flush cycles.

---
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode-stage instruction and branch status in,
// stall/flush/forwarding controls and performance counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      inst_d;
   logic             valid_d;
   logic             br_taken_x;
   logic             stall_f;
   logic             stall_d;
   logic             flush_f;
   logic             flush_d;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output inst_d, valid_d, br_taken_x,
      input  stall_f, stall_d, flush_f, flush_d, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  inst_d, valid_d, br_taken_x,
      output stall_f, stall_d, flush_f, flush_d, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: X/M/W destination scoreboard, load-use or
// full-RAW stalling, branch flush, execute-stage forwarding selects.
module hazard_ctrl #(
   parameter int CNT_W  = 32,
   parameter bit FWD_EN = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BCC   = 7'b1100011;
   localparam logic [6:0] OP_LCC   = 7'b0000011;
   localparam logic [6:0] OP_SCC   = 7'b0100011;
   localparam logic [6:0] OP_ICC   = 7'b0010011;
   localparam logic [6:0] OP_RCC   = 7'b0110011;

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
   } sb_ent_t;

   function automatic sb_ent_t decode(input logic [31:0] inst);
      sb_ent_t e;
      e     = '0;
      e.rd  = inst[11:7];
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      case (inst[6:0])
         OP_LUI, OP_AUIPC, OP_JAL: e.we = 1'b1;
         OP_JALR, OP_ICC: begin
            e.we   = 1'b1;
            e.use1 = 1'b1;
         end
         OP_LCC: begin
            e.we   = 1'b1;
            e.use1 = 1'b1;
            e.ld   = 1'b1;
         end
         OP_BCC, OP_SCC: begin
            e.use1 = 1'b1;
            e.use2 = 1'b1;
         end
         OP_RCC: begin
            e.we   = 1'b1;
            e.use1 = 1'b1;
            e.use2 = 1'b1;
         end
         default: ;
      endcase
      // x0 is hardwired, so folding rd!=0 into we keeps every consumer simple
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   function automatic logic match(input logic vld, input sb_ent_t s, input sb_ent_t d);
      return vld & s.we & ((d.use1 & (d.rs1 == s.rd)) | (d.use2 & (d.rs2 == s.rd)));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic use_x, input logic [4:0] rs,
                                          input logic vld_m, input sb_ent_t m,
                                          input logic vld_w, input sb_ent_t w);
      // load data is not available until W, so an M-stage load never forwards
      if (use_x && vld_m && m.we && (m.rd == rs) && !m.ld) return 2'b01;
      else if (use_x && vld_w && w.we && (w.rd == rs))     return 2'b10;
      else                                                 return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   sb_ent_t          dec_d;
   sb_ent_t          ent_p0, ent_p1, ent_p2;
   logic             vld_p0, vld_p1, vld_p2;
   logic             hazard, stall, flush_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             unused_inst_bits;

   assign unused_inst_bits = ^{hz.inst_d[31:25], hz.inst_d[14:12]};

   // D stage: decode and hazard detection against the in-flight entries
   always_comb begin
      dec_d = decode(hz.inst_d);
      if (FWD_EN) hazard = match(vld_p0, ent_p0, dec_d) & ent_p0.ld;
      else        hazard = match(vld_p0, ent_p0, dec_d) | match(vld_p1, ent_p1, dec_d);
      hazard  = hazard & hz.valid_d;
      stall   = hazard & ~hz.br_taken_x;
      flush_d = hz.br_taken_x | stall;
   end

   assign hz.stall_f   = stall;
   assign hz.stall_d   = stall;
   assign hz.flush_f   = hz.br_taken_x;
   assign hz.flush_d   = flush_d;
   assign hz.fwd_a     = FWD_EN ? fwd_sel(vld_p0 & ent_p0.use1, ent_p0.rs1,
                                          vld_p1, ent_p1, vld_p2, ent_p2) : 2'b00;
   assign hz.fwd_b     = FWD_EN ? fwd_sel(vld_p0 & ent_p0.use2, ent_p0.rs2,
                                          vld_p1, ent_p1, vld_p2, ent_p2) : 2'b00;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

   // X -> M -> W: valid bits and counters carry reset, entry payload does not
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         vld_p0 <= hz.valid_d & ~flush_d;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         if (stall)         stall_cnt_q <= sat_inc(stall_cnt_q);
         if (hz.br_taken_x) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      ent_p0 <= dec_d;
      ent_p1 <= ent_p0;
      ent_p2 <= ent_p1;
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding instance (k=0) and stall-only instance
// with a 3-bit counter (k=1), checked against a pipeline-occupancy model.
module tb_hazard_ctrl;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BCC   = 7'b1100011;
   localparam logic [6:0] OP_LCC   = 7'b0000011;
   localparam logic [6:0] OP_SCC   = 7'b0100011;
   localparam logic [6:0] OP_ICC   = 7'b0010011;
   localparam logic [6:0] OP_RCC   = 7'b0110011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   typedef struct packed {
      logic [3:0]  ctrl;   // {stall_f, stall_d, flush_f, flush_d}
      logic [3:0]  fwd;    // {fwd_a, fwd_b}
      logic [31:0] sc;
      logic [31:0] fc;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn_v [2];
   logic        vld_v  [2];
   logic        br_v   [2];
   logic [31:0] inst_v [2];

   hazard_ctrl_if #(.CNT_W(32)) if0 ();
   hazard_ctrl_if #(.CNT_W(3))  if1 ();

   assign if0.inst_d     = inst_v[0];
   assign if0.valid_d    = vld_v[0];
   assign if0.br_taken_x = br_v[0];
   assign if1.inst_d     = inst_v[1];
   assign if1.valid_d    = vld_v[1];
   assign if1.br_taken_x = br_v[1];

   hazard_ctrl #(.CNT_W(32), .FWD_EN(1'b1)) dut0 (.clk(clk), .rst_n(rstn_v[0]), .hz(if0));
   hazard_ctrl #(.CNT_W(3),  .FWD_EN(1'b0)) dut1 (.clk(clk), .rst_n(rstn_v[1]), .hz(if1));

   // model: instruction word occupying X(0), M(1), W(2) and event tallies
   logic        mv [2][3];
   logic [31:0] mi [2][3];
   logic [31:0] scnt [2];
   logic [31:0] fcnt [2];
   resp_t q0[$];
   resp_t q1[$];
   int errors = 0;
   int checks = 0;

   function automatic bit known(logic [6:0] o);
      return o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BCC, OP_LCC, OP_SCC, OP_ICC, OP_RCC};
   endfunction
   function automatic bit wr(logic [31:0] i);
      return known(i[6:0]) && !(i[6:0] inside {OP_BCC, OP_SCC}) && i[11:7] != 5'd0;
   endfunction
   function automatic bit rd1(logic [31:0] i);
      return known(i[6:0]) && !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction
   function automatic bit rd2(logic [31:0] i);
      return i[6:0] inside {OP_BCC, OP_SCC, OP_RCC};
   endfunction
   function automatic bit ld(logic [31:0] i);
      return i[6:0] == OP_LCC;
   endfunction
   function automatic bit writes(logic v, logic [31:0] i, logic [4:0] r);
      return v && wr(i) && i[11:7] == r;
   endfunction
   function automatic bit depends(int k, int s, logic [31:0] i);
      return (rd1(i) && writes(mv[k][s], mi[k][s], i[19:15])) ||
             (rd2(i) && writes(mv[k][s], mi[k][s], i[24:20]));
   endfunction
   function automatic logic [31:0] cmax(int k);
      return (k == 0) ? 32'hFFFF_FFFF : 32'd7;
   endfunction

   function automatic bit exp_stall(int k);
      bit haz;
      if (k == 0) haz = mv[0][0] && ld(mi[0][0]) && depends(0, 0, inst_v[0]);
      else        haz = depends(1, 0, inst_v[1]) || depends(1, 1, inst_v[1]);
      return vld_v[k] && haz && !br_v[k];
   endfunction

   function automatic logic [1:0] exp_fwd(int k, bit use_x, logic [4:0] r);
      if (k != 0 || !mv[0][0] || !use_x) return 2'b00;
      if (writes(mv[0][1], mi[0][1], r) && !ld(mi[0][1])) return 2'b01;
      if (writes(mv[0][2], mi[0][2], r)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic resp_t expect_resp(int k);
      resp_t r;
      bit st;
      logic [31:0] xi;
      st     = exp_stall(k);
      xi     = mi[k][0];
      r.ctrl = {st, st, br_v[k], br_v[k] | st};
      r.fwd  = {exp_fwd(k, rd1(xi), xi[19:15]), exp_fwd(k, rd2(xi), xi[24:20])};
      r.sc   = scnt[k];
      r.fc   = fcnt[k];
      return r;
   endfunction

   function automatic resp_t actual(int k);
      resp_t a;
      if (k == 0) begin
         a.ctrl = {if0.stall_f, if0.stall_d, if0.flush_f, if0.flush_d};
         a.fwd  = {if0.fwd_a, if0.fwd_b};
         a.sc   = if0.stall_cnt;
         a.fc   = if0.flush_cnt;
      end else begin
         a.ctrl = {if1.stall_f, if1.stall_d, if1.flush_f, if1.flush_d};
         a.fwd  = {if1.fwd_a, if1.fwd_b};
         a.sc   = 32'(if1.stall_cnt);
         a.fc   = 32'(if1.flush_cnt);
      end
      return a;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rstn_v[k]) begin
            for (int s = 0; s < 3; s++) mv[k][s] <= 1'b0;
            scnt[k] <= '0;
            fcnt[k] <= '0;
         end else begin
            if (exp_stall(k) && scnt[k] != cmax(k)) scnt[k] <= scnt[k] + 1;
            if (br_v[k] && fcnt[k] != cmax(k))      fcnt[k] <= fcnt[k] + 1;
            mv[k][2] <= mv[k][1];
            mi[k][2] <= mi[k][1];
            mv[k][1] <= mv[k][0];
            mi[k][1] <= mi[k][0];
            mv[k][0] <= vld_v[k] && !br_v[k] && !exp_stall(k);
            mi[k][0] <= inst_v[k];
         end
      end
   end

   task automatic chk(int k, string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL dut%0d %s at %0t: got=%h want=%h", k, name, $time, got, want);
      end
   endtask

   task automatic compare(int k, resp_t e);
      resp_t a;
      a = actual(k);
      chk(k, "ctrl",      32'(a.ctrl), 32'(e.ctrl));
      chk(k, "fwd",       32'(a.fwd),  32'(e.fwd));
      chk(k, "stall_cnt", a.sc, e.sc);
      chk(k, "flush_cnt", a.fc, e.fc);
   endtask

   always @(negedge clk) begin
      if (q0.size() != 0) compare(0, q0.pop_front());
      if (q1.size() != 0) compare(1, q1.pop_front());
   end

   task automatic step(int k, bit rn, bit v, logic [31:0] ins, bit br, output bit st);
      @(posedge clk);
      #1;
      rstn_v[k] = rn;
      vld_v[k]  = v;
      inst_v[k] = ins;
      br_v[k]   = br;
      if (k == 0) q0.push_back(expect_resp(0));
      else        q1.push_back(expect_resp(1));
      st = exp_stall(k);
   endtask

   task automatic issue(int k, logic [31:0] ins, bit br);
      bit st;
      int n;
      n = 0;
      do begin
         step(k, 1'b1, 1'b1, ins, br, st);
         n++;
      end while (st && n < 4);
      checks++;
      if (st) begin
         errors++;
         $display("FAIL dut%0d stall_bound: still stalled after %0d cycles, want release", k, n);
      end
   endtask

   task automatic idle(int k, int n);
      bit st;
      repeat (n) step(k, 1'b1, 1'b0, 32'h0, 1'b0, st);
   endtask

   function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
      return {f7, rs2, rs1, 3'b000, rd, OP_RCC};
   endfunction
   function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
      return {12'd0, rs1, 3'b010, rd, OP_LCC};
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [31:0] i;
      logic [6:0]  o;
      case ($urandom_range(0, 9))
         0: o = OP_LUI;   1: o = OP_AUIPC; 2: o = OP_JAL;  3: o = OP_JALR;
         4: o = OP_BCC;   5: o = OP_LCC;   6: o = OP_SCC;  7: o = OP_ICC;
         8: o = OP_RCC;   default: o = OP_SYS;
      endcase
      i        = $urandom;
      i[6:0]   = o;
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
      return i;
   endfunction

   task automatic rand_run(int k, int n);
      logic [31:0] ins;
      bit v, br, rn, st;
      st  = 1'b0;
      ins = 32'h0;
      v   = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!st) begin
            ins = gen_inst();
            v   = $urandom_range(0, 4) != 0;
         end
         br = $urandom_range(0, 7) == 0;
         rn = $urandom_range(0, 59) != 0;
         step(k, rn, v, ins, br, st);
      end
   endtask

   task automatic drive_fwd();
      bit st;
      step(0, 1'b0, 1'b1, rtype(5'd1, 5'd2, 5'd3, 7'h00), 1'b0, st);
      step(0, 1'b0, 1'b1, rtype(5'd4, 5'd1, 5'd1, 7'h00), 1'b0, st);
      idle(0, 2);
      issue(0, rtype(5'd1, 5'd2, 5'd3, 7'h00), 1'b0);
      issue(0, rtype(5'd4, 5'd1, 5'd5, 7'h20), 1'b0);
      issue(0, rtype(5'd6, 5'd1, 5'd0, 7'h00), 1'b0);
      idle(0, 3);
      issue(0, lw(5'd5, 5'd1), 1'b0);
      issue(0, rtype(5'd6, 5'd7, 5'd5, 7'h00), 1'b0);
      idle(0, 3);
      issue(0, lw(5'd0, 5'd1), 1'b0);
      issue(0, rtype(5'd6, 5'd0, 5'd0, 7'h00), 1'b0);
      idle(0, 3);
      issue(0, lw(5'd5, 5'd1), 1'b0);
      issue(0, rtype(5'd6, 5'd7, 5'd5, 7'h00), 1'b1);
      idle(0, 3);
      rand_run(0, 1500);
   endtask

   task automatic drive_stall_only();
      bit st;
      step(1, 1'b0, 1'b1, rtype(5'd1, 5'd2, 5'd3, 7'h00), 1'b0, st);
      step(1, 1'b0, 1'b1, rtype(5'd2, 5'd1, 5'd1, 7'h00), 1'b0, st);
      idle(1, 1);
      issue(1, rtype(5'd1, 5'd2, 5'd3, 7'h00), 1'b0);
      issue(1, rtype(5'd2, 5'd1, 5'd1, 7'h00), 1'b0);
      idle(1, 3);
      repeat (6) begin
         issue(1, rtype(5'd1, 5'd2, 5'd3, 7'h00), 1'b0);
         issue(1, rtype(5'd2, 5'd1, 5'd1, 7'h00), 1'b0);
      end
      idle(1, 2);
      rand_run(1, 1500);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rstn_v[k] = 1'b0;
         vld_v[k]  = 1'b0;
         br_v[k]   = 1'b0;
         inst_v[k] = 32'h0;
         scnt[k]   = '0;
         fcnt[k]   = '0;
         for (int s = 0; s < 3; s++) begin
            mv[k][s] = 1'b0;
            mi[k][s] = 32'h0;
         end
      end
      fork
         drive_fwd();
         drive_stall_only();
      join
      repeat (2) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
